// File: rtl/des_decrypt_key_sched_pkg.sv
// Shared DES key-schedule definitions: widths, the rotation mask, the PC-2 table
// and the 28-bit half rotations used by both the encrypt and decrypt schedules.
package des_decrypt_key_sched_pkg;

    localparam int KEY56_W = 56;
    localparam int RK_W    = 48;
    localparam int HALF_W  = 28;

    // Encrypt-round-indexed: bit i set -> round i+1 shifts by one, else by two.
    localparam logic [15:0] DES_SHIFT1_MASK = 16'h8103;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // PC-2 source positions, 1-based from the MSB of C||D, listed MSB-first.
    localparam int unsigned PC2_TAB [RK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n);
        logic [2*HALF_W-1:0] xx;
        xx = {x, x} << n;
        return xx[2*HALF_W-1:HALF_W];
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n);
        logic [2*HALF_W-1:0] xx;
        xx = {x, x} >> n;
        return xx[HALF_W-1:0];
    endfunction

    // Right-rotation amount applied when stepping to decrypt round i (1..15);
    // that step undoes encrypt round 17-i, whose mask bit is 16-i.
    function automatic logic [1:0] rot_amt(input logic [15:0] mask,
                                           input logic [3:0]  i);
        logic [3:0] bit_sel;
        bit_sel = 4'd0 - i;
        return mask[bit_sel] ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/des_decrypt_key_sched_p_box_56_48.sv
// DES PC-2 compression permutation: 56-bit C||D to a 48-bit round key.
module p_box_56_48
    import des_decrypt_key_sched_pkg::*;
(
    input  logic [KEY56_W-1:0] cd,
    output logic [RK_W-1:0]    rk
);

    generate
        for (genvar gi = 0; gi < RK_W; gi++) begin : g_pc2
            assign rk[RK_W-1-gi] = cd[KEY56_W - PC2_TAB[gi]];
        end
    endgenerate

endmodule

// File: rtl/des_decrypt_key_sched.sv
// Iterative DES decryption key schedule: streams K16..K1 over valid/ready by
// right-rotating the C and D halves of the loaded post-PC-1 key.
module des_decrypt_key_sched
    import des_decrypt_key_sched_pkg::*;
#(
    parameter logic [15:0] SHIFT1_MASK = DES_SHIFT1_MASK
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [KEY56_W-1:0] key_in,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [RK_W-1:0]    round_key_out,
    output logic [3:0]         round_idx,
    output logic               busy,
    output logic               done
);

    state_t             state_reg, state_next;
    logic [KEY56_W-1:0] cd_reg, cd_next;
    logic [3:0]         idx_reg, idx_next;
    logic               done_reg, done_next;

    logic [HALF_W-1:0]  c_half, d_half;
    logic [1:0]         amt;

    assign c_half = cd_reg[KEY56_W-1:HALF_W];
    assign d_half = cd_reg[HALF_W-1:0];
    assign amt    = rot_amt(SHIFT1_MASK, idx_reg + 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cd_reg    <= '0;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cd_reg    <= cd_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cd_next    = cd_reg;
        idx_next   = idx_reg;
        done_next  = 1'b0;

        // Abort wins over start and beat bookkeeping; cd_reg is simply left alone.
        if (abort) begin
            state_next = ST_IDLE;
            idx_next   = 4'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        // Total rotation over a full schedule is 28, so K16 uses C0||D0.
                        cd_next    = key_in;
                        idx_next   = 4'd0;
                        state_next = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready) begin
                        if (idx_reg == 4'd15) begin
                            state_next = ST_IDLE;
                            idx_next   = 4'd0;
                            done_next  = 1'b1;
                        end else begin
                            idx_next = idx_reg + 4'd1;
                            cd_next  = {rotr28(c_half, amt), rotr28(d_half, amt)};
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    idx_next   = 4'd0;
                end
            endcase
        end
    end

    p_box_56_48 u_pc2 (
        .cd (cd_reg),
        .rk (round_key_out)
    );

    assign rk_valid  = (state_reg == ST_EMIT);
    assign busy      = rk_valid;
    assign round_idx = idx_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_des_decrypt_key_sched.sv
// Scoreboard bench for the DES decrypt key schedule: expected keys come from an
// encrypt-direction (left-rotation) model and are consumed in reverse order.
module tb_des_decrypt_key_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        rk_ready = 1'b0;
    logic [55:0] key_in = '0;
    logic        rk_valid, busy, done;
    logic [47:0] round_key_out;
    logic [3:0]  round_idx;

    always #5 clk = ~clk;

    des_decrypt_key_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .key_in        (key_in),
        .rk_valid      (rk_valid),
        .rk_ready      (rk_ready),
        .round_key_out (round_key_out),
        .round_idx     (round_idx),
        .busy          (busy),
        .done          (done)
    );

    localparam logic [55:0] KV_KEY = 56'hF0CCAAF556678F;

    localparam int ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef struct packed {
        logic [3:0]  idx;
        logic [47:0] key;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    logic        exp_done = 1'b0;
    logic [47:0] obs_key [16];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
        return r;
    endfunction

    // Encrypt-side chain K1..K16, queued in decrypt order.
    task automatic push_schedule(input logic [55:0] k);
        logic [27:0] c, d;
        logic [47:0] ks [16];
        exp_t        e;
        c = k[55:28];
        d = k[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < ENC_SHIFT[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = pc2({c, d});
        end
        for (int r = 0; r < 16; r++) begin
            e.idx = 4'(r);
            e.key = ks[15-r];
            sb.push_back(e);
        end
    endtask

    task automatic cycle(input logic s, input logic a, input logic [55:0] k, input logic r);
        logic exp_valid;
        exp_t e;
        @(negedge clk);
        start = s; abort = a; key_in = k; rk_ready = r;
        cyc++;
        #1;
        exp_valid = (sb.size() != 0);
        check_val("done", done, exp_done);
        check_val("rk_valid", rk_valid, exp_valid);
        check_val("busy", busy, exp_valid);
        if (done) done_cyc = cyc;
        exp_done = 1'b0;
        if (exp_valid) begin
            e = sb[0];
            check_val("round_idx", round_idx, e.idx);
            check_val("round_key", round_key_out, e.key);
            if (r) begin
                void'(sb.pop_front());
                obs_key[e.idx] = round_key_out;
                $display("beat cyc=%0d idx=%0d key=%h", cyc, round_idx, round_key_out);
                if (e.idx == 4'd15 && !a) exp_done = 1'b1;
            end
        end
        if (a) sb.delete();
        else if (!exp_valid && s) push_schedule(k);
    endtask

    task automatic drain(input bit rand_ready);
        int n;
        n = 0;
        while ((sb.size() != 0 || exp_done) && n < 400) begin
            cycle(1'b0, 1'b0, 56'h0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        check_val("drained", sb.size() == 0 && !exp_done, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, rk_valid, 1'b0);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_done"}, done, 1'b0);
        check_val({tag, "_idx"}, round_idx, 4'd0);
        check_val({tag, "_key"}, round_key_out, 48'h0);
    endtask

    initial begin
        int          start_cyc;
        logic [55:0] k;

        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 56'h0, 1'b1);

        // Known vector, full throughput
        cycle(1'b1, 1'b0, KV_KEY, 1'b1);
        start_cyc = cyc;
        drain(1'b0);
        check_val("kv_k16", obs_key[0], 48'hCB3D8B0E17F5);
        check_val("kv_k1", obs_key[15], 48'h1B02EFFC7072);
        check_val("kv_done_latency", done_cyc - start_cyc, 17);

        // Random keys, full throughput then backpressure
        for (int t = 0; t < 6; t++) begin
            k = {$urandom(), $urandom()} >> 8;
            cycle(1'b1, 1'b0, k, 1'b1);
            drain(t >= 2);
        end

        // Start pulses while busy are ignored; start in the done cycle is taken
        cycle(1'b1, 1'b0, KV_KEY, 1'b1);
        for (int i = 1; i <= 16; i++)
            cycle((i == 6 || i == 16) ? 1'b1 : 1'b0, 1'b0, 56'h123456789ABCDE, 1'b1);
        k = 56'h0F1E2D3C4B5A69;
        cycle(1'b1, 1'b0, k, 1'b1);
        drain(1'b0);

        // Abort at round 7 coinciding with a beat, then with ready low
        for (int v = 0; v < 2; v++) begin
            cycle(1'b1, 1'b0, KV_KEY ^ 56'(v), 1'b1);
            for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 56'h0, 1'b1);
            cycle(1'b0, 1'b1, 56'h0, v == 0);
            cycle(1'b0, 1'b0, 56'h0, 1'b1);
            cycle(1'b0, 1'b0, 56'h0, 1'b1);
        end
        cycle(1'b0, 1'b1, 56'h0, 1'b1);
        cycle(1'b1, 1'b1, KV_KEY, 1'b1);
        cycle(1'b1, 1'b0, KV_KEY, 1'b1);
        drain(1'b0);
        check_val("abort_restart_k16", obs_key[0], 48'hCB3D8B0E17F5);

        // Asynchronous reset mid-schedule, then restart
        cycle(1'b1, 1'b0, KV_KEY, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 56'h0, 1'b1);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        exp_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 56'h0, 1'b1);
        cycle(1'b1, 1'b0, KV_KEY, 1'b1);
        drain(1'b1);
        check_val("rst_restart_k16", obs_key[0], 48'hCB3D8B0E17F5);
        check_val("rst_restart_k1", obs_key[15], 48'h1B02EFFC7072);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
